gray_counter: RTL



---
 rtl/gray_counter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gray_counter.sv
// Gray-code counter: up/down step, binary parallel load, wrap or saturate at terminal count.
// Optional single-bit-change checker on gray is enabled by defining GRAY_COUNTER_CHECK_EN.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrapped,
    output logic             err
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } op_e;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    op_e              op_s;
    logic [WIDTH-1:0] step_val_s;
    logic             tc_s;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrapped_q, wrapped_d;

    // Operation select, terminal count and candidate step value.
    always_comb begin
        op_s = OP_HOLD;
        if (load) begin
            op_s = OP_LOAD;
        end else if (en) begin
            op_s = OP_STEP;
        end else begin
            op_s = OP_HOLD;
        end

        if (up) begin
            step_val_s = bin_q + WIDTH'(1);
            tc_s       = (bin_q == ALL_ONES);
        end else begin
            step_val_s = bin_q - WIDTH'(1);
            tc_s       = (bin_q == ALL_ZERO);
        end
    end

    // Next-state: a terminal-count step either wraps with a pulse or holds.
    always_comb begin
        bin_d     = bin_q;
        wrapped_d = 1'b0;
        case (op_s)
            OP_LOAD: begin
                bin_d     = load_bin;
                wrapped_d = 1'b0;
            end
            OP_STEP: begin
                if (tc_s) begin
                    if (WRAP) begin
                        bin_d     = step_val_s;
                        wrapped_d = 1'b1;
                    end else begin
                        bin_d     = bin_q;
                        wrapped_d = 1'b0;
                    end
                end else begin
                    bin_d     = step_val_s;
                    wrapped_d = 1'b0;
                end
            end
            OP_HOLD: begin
                bin_d     = bin_q;
                wrapped_d = 1'b0;
            end
            default: begin
                bin_d     = bin_q;
                wrapped_d = 1'b0;
            end
        endcase
        gray_d = bin2gray(bin_d);
    end

    // Count registers; bin and gray always load on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q     <= ALL_ZERO;
            gray_q    <= ALL_ZERO;
            wrapped_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bin     = bin_q;
    assign gray    = gray_q;
    assign wrapped = wrapped_q;
    assign tc      = tc_s;

`ifdef GRAY_COUNTER_CHECK_EN
    function automatic logic multi_bit(input logic [WIDTH-1:0] x);
        return |(x & (x - WIDTH'(1)));
    endfunction

    logic [WIDTH-1:0] prev_gray_q;
    logic             stepped_q;
    logic             err_q;

    // Compare gray against its previous value one cycle after every step edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_gray_q <= ALL_ZERO;
            stepped_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= gray_q;
            stepped_q   <= (op_s == OP_STEP);
            if (stepped_q && multi_bit(gray_q ^ prev_gray_q)) begin
                err_q <= 1'b1;
            end else begin
                err_q <= err_q;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
